// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Instruction-memory bus between the fetch unit and instruction memory.
//   imem_req_valid  fetch -> mem   read request valid
//   imem_req_addr   fetch -> mem   word-aligned read address
//   imem_req_ready  mem -> fetch   memory accepts the request this cycle
//   imem_rsp_valid  mem -> fetch   read data valid (in request order)
//   imem_rsp_data   mem -> fetch   read data
// Modports: master (fetch unit side), slave (memory side).
// -----------------------------------------------------------------------------
interface inst_fetch_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch unit: owns the program counter, issues in-order reads to
// instruction memory, buffers returned words in a DEPTH-entry FIFO of
// {pc, data} and presents the head to the control unit. A taken redirect
// (PCSel on a consumed instruction) restarts fetch at alu_out and discards all
// buffered and in-flight wrong-path words.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   DEPTH       FIFO entries and maximum outstanding requests (power of 2, >=2)
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   imem        instruction-memory bus (inst_fetch_if.master)
//   PCSel       redirect request, qualified by inst_valid & inst_ready
//   alu_out     redirect target (bits [1:0] ignored)
//   inst        instruction, NOP (32'h0000_0013) when inst_valid is low
//   inst_pc     PC of inst, 0 when inst_valid is low
//   inst_valid  inst is valid
//   inst_ready  core consumes inst this cycle
// Build option:
//   IFETCH_BYPASS_EN  a non-dropped response arriving while the FIFO is empty
//                     is presented on inst in the same cycle.
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  imem,
    input  logic          PCSel,
    input  logic [31:0]   alu_out,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    output logic          inst_valid,
    input  logic          inst_ready
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam int          SW  = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;          // pc of the oldest non-dropped in-flight request
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];

    logic          w_fifo_empty;
    logic          w_rsp_fire;
    logic          w_rsp_keep;
    logic          w_bypass;
    logic          w_pop;
    logic          w_fifo_pop;
    logic          w_push;
    logic          w_redirect;
    logic          w_req_fire;
    logic [SW-1:0] w_credit_used;
    logic [SW-1:0] w_credit_limit;
    logic [31:0]   w_target;
    logic [1:0]    w_unused_alu_lsbs;

    assign w_target          = {alu_out[31:2], 2'b00};
    assign w_unused_alu_lsbs = alu_out[1:0];

    assign w_fifo_empty = (r_count == '0);
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign w_rsp_fire   = imem.imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_keep   = w_rsp_fire && (r_drop_cnt == '0);

`ifdef IFETCH_BYPASS_EN
    assign w_bypass = w_rsp_keep && w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // NOTE: every output gets a default before the branches, so no latch is inferred.
    always_comb begin
        inst_valid = 1'b0;
        inst       = NOP;
        inst_pc    = '0;
        if (!w_fifo_empty) begin
            inst_valid = 1'b1;
            inst       = r_fifo_data[r_rd_ptr];
            inst_pc    = r_fifo_pc[r_rd_ptr];
        end else if (w_bypass) begin
            inst_valid = 1'b1;
            inst       = imem.imem_rsp_data;
            inst_pc    = r_rsp_pc;
        end
    end

    assign w_pop      = inst_valid && inst_ready;
    assign w_redirect = w_pop && PCSel;
    assign w_fifo_pop = w_pop && !w_fifo_empty;
    // A bypassed word consumed this cycle never occupies a FIFO slot; a redirect
    // discards whatever arrives in its cycle.
    assign w_push     = w_rsp_keep && !w_redirect && !(w_bypass && w_pop);

    // Every in-flight or buffered word holds one credit. A pop this cycle frees
    // its credit immediately, which sustains one fetch per cycle while never
    // letting in-flight plus buffered words exceed DEPTH.
    assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_credit_limit = SW'(DEPTH) + SW'(w_pop);

    // rst_n gates the request combinationally so it drops as soon as reset asserts.
    assign imem.imem_req_valid = rst_n && !w_redirect && (w_credit_used < w_credit_limit);
    assign imem.imem_req_addr  = r_fetch_pc;
    assign w_req_fire          = imem.imem_req_valid && imem.imem_req_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (w_redirect) begin
            // No request issues in a redirect cycle, so every word still in
            // flight after this edge belongs to the wrong path.
            r_fetch_pc    <= w_target;
            r_rsp_pc      <= w_target;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_outstanding <= r_outstanding - CW'(w_rsp_fire);
            r_drop_cnt    <= r_outstanding - CW'(w_rsp_fire);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_rsp_keep) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            if (w_rsp_fire && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);
            r_count       <= r_count + CW'(w_push) - CW'(w_fifo_pop);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: FIFO storage is not reset; r_count and the pointers decide which
    // entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
            r_fifo_data[r_wr_ptr] <= imem.imem_rsp_data;
        end
    end

`ifndef SYNTHESIS
    a_rsp_has_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n)
        imem.imem_rsp_valid |-> (r_outstanding != '0)
    );
`endif

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
module tb_inst_fetch;
    localparam int          M_DEPTH = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;
`ifdef IFETCH_BYPASS_EN
    localparam int          FILL_LAT = 1;
`else
    localparam int          FILL_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main DUT (RESET_PC 0, DEPTH 4)
    logic        m_pcsel, m_inst_ready, m_inst_valid;
    logic [31:0] m_alu, m_inst, m_inst_pc;
    // wrap DUT (RESET_PC near top of address space, DEPTH 2)
    logic        w_pcsel, w_inst_ready, w_inst_valid;
    logic [31:0] w_alu, w_inst, w_inst_pc;

    inst_fetch_if m_if ();
    inst_fetch_if w_if ();

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(M_DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem(m_if),
        .PCSel(m_pcsel), .alu_out(m_alu),
        .inst(m_inst), .inst_pc(m_inst_pc), .inst_valid(m_inst_valid), .inst_ready(m_inst_ready)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem(w_if),
        .PCSel(w_pcsel), .alu_out(w_alu),
        .inst(w_inst), .inst_pc(w_inst_pc), .inst_valid(w_inst_valid), .inst_ready(w_inst_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // memory model: in-order queue of accepted requests with their due cycle
    req_t mq[$];
    req_t wq[$];
    int   lat_min, lat_max, ready_pct, gap_pct, iready_pct, pcsel_pct;
    logic [31:0] redir_map [logic [31:0]];

    // architectural reference: next pc the core must see, next address to fetch
    logic [31:0] exp_pc, exp_req, redir_tgt;
    bit          redir_pending;

    // per-cycle observations
    bit          obs_req_fire, obs_req_valid, obs_inst_valid, obs_redirect;
    logic [31:0] obs_inst_pc;
    int          last_redir_inflight, n_consumed;
    logic [31:0] w_addrs[$];
    logic [31:0] w_pcs[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h9E37_79B1;
    endfunction

    // One clock cycle. Entered just after a falling edge, leaves at the next one.
    task automatic step();
        bit          rsp_taken, w_taken;
        logic [31:0] tgt;
        rsp_taken = (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) >= gap_pct);
        m_if.imem_rsp_valid = rsp_taken;
        m_if.imem_rsp_data  = $urandom();
        if (rsp_taken) m_if.imem_rsp_data = mem_word(mq[0].addr);
        m_if.imem_req_ready = ($urandom_range(99) < ready_pct);
        m_inst_ready        = ($urandom_range(99) < iready_pct);
        w_taken = (wq.size() > 0) && (wq[0].due <= cyc);
        w_if.imem_rsp_valid = w_taken;
        w_if.imem_rsp_data  = 32'h0;
        if (w_taken) w_if.imem_rsp_data = mem_word(wq[0].addr);
        #1;
        m_pcsel = 1'b0;
        m_alu   = $urandom();
        if (m_inst_valid) begin
            if (redir_map.exists(m_inst_pc)) begin
                m_pcsel = 1'b1;
                m_alu   = redir_map[m_inst_pc];
            end else if ($urandom_range(99) < pcsel_pct) begin
                m_pcsel = 1'b1;
                m_alu   = $urandom_range(32'h3FF, 0);
            end
        end
        #1;
        if (redir_pending) begin
            checks++;
            if (m_if.imem_req_valid !== 1'b1 || m_if.imem_req_addr !== redir_tgt) begin
                failures++;
                $display("FAIL redirect_next_req: valid=%b addr=%h, required valid=1 addr=%h",
                         m_if.imem_req_valid, m_if.imem_req_addr, redir_tgt);
            end
            redir_pending = 1'b0;
        end
        obs_req_valid = m_if.imem_req_valid;
        obs_req_fire  = m_if.imem_req_valid && m_if.imem_req_ready;
        if (obs_req_fire) begin
            checks++;
            if (m_if.imem_req_addr !== exp_req) begin
                failures++;
                $display("FAIL req_addr: got %h, required %h", m_if.imem_req_addr, exp_req);
            end
            mq.push_back('{addr: m_if.imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
            exp_req = exp_req + 32'd4;
        end
        if (rsp_taken) void'(mq.pop_front());
        obs_inst_valid = m_inst_valid;
        obs_inst_pc    = m_inst_pc;
        obs_redirect   = 1'b0;
        if (m_inst_valid) begin
            checks++;
            if (m_inst_pc !== exp_pc || m_inst !== mem_word(exp_pc)) begin
                failures++;
                $display("FAIL inst: pc=%h inst=%h, required pc=%h inst=%h",
                         m_inst_pc, m_inst, exp_pc, mem_word(exp_pc));
            end
            if (m_inst_ready) begin
                n_consumed++;
                if (m_pcsel) begin
                    tgt = {m_alu[31:2], 2'b00};
                    checks++;
                    if (m_if.imem_req_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL redirect_cycle_req: valid=%b, required 0", m_if.imem_req_valid);
                    end
                    exp_pc        = tgt;
                    exp_req       = tgt;
                    redir_pending = 1'b1;
                    redir_tgt     = tgt;
                    obs_redirect  = 1'b1;
                    last_redir_inflight = mq.size();
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end else begin
            checks++;
            if (m_inst !== NOP || m_inst_pc !== 32'h0) begin
                failures++;
                $display("FAIL idle_outputs: inst=%h pc=%h, required inst=%h pc=0", m_inst, m_inst_pc, NOP);
            end
        end
        if (w_if.imem_req_valid && w_if.imem_req_ready) begin
            wq.push_back('{addr: w_if.imem_req_addr, due: cyc + 1});
            w_addrs.push_back(w_if.imem_req_addr);
        end
        if (w_taken) void'(wq.pop_front());
        if (w_inst_valid) w_pcs.push_back(w_inst_pc);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_mode(input int lmin, input int lmax, input int rdy, input int gap,
                            input int irdy, input int psel);
        lat_min = lmin; lat_max = lmax; ready_pct = rdy;
        gap_pct = gap; iready_pct = irdy; pcsel_pct = psel;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_if.imem_req_ready = 1'b0; m_if.imem_rsp_valid = 1'b0; m_if.imem_rsp_data = '0;
        m_inst_ready = 1'b0; m_pcsel = 1'b0; m_alu = '0;
        w_if.imem_rsp_valid = 1'b0; w_if.imem_rsp_data = '0;
        repeat (2) @(negedge clk);
        mq.delete(); wq.delete(); w_addrs.delete(); w_pcs.delete(); redir_map.delete();
        exp_pc = 32'h0; exp_req = 32'h0; redir_pending = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_if.imem_req_valid !== 1'b0 || m_inst_valid !== 1'b0 || m_inst !== NOP || m_inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_values: req_valid=%b inst_valid=%b inst=%h pc=%h, required 0 0 %h 0",
                     m_if.imem_req_valid, m_inst_valid, m_inst, m_inst_pc, NOP);
        end
        do_reset();
        #1;
        checks++;
        if (m_if.imem_req_valid !== 1'b1 || m_if.imem_req_addr !== 32'h0 || m_inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_req: valid=%b addr=%h inst_valid=%b, required 1 00000000 0",
                     m_if.imem_req_valid, m_if.imem_req_addr, m_inst_valid);
        end
        checks++;
        if (w_if.imem_req_valid !== 1'b1 || w_if.imem_req_addr !== 32'hFFFF_FFF8) begin
            failures++;
            $display("FAIL wrap_first_req: valid=%b addr=%h, required 1 fffffff8",
                     w_if.imem_req_valid, w_if.imem_req_addr);
        end
    endtask

    task automatic test_stream();
        int fa, fv, nc, nv;
        fa = -1; fv = -1; nc = 0; nv = 0;
        do_reset();
        set_mode(1, 1, 100, 0, 100, 0);
        for (int i = 0; i < 16; i++) begin
            step();
            if (obs_req_fire && fa < 0) fa = i;
            if (obs_inst_valid && fv < 0) fv = i;
            if (fv >= 0) begin
                nc++;
                if (obs_inst_valid) nv++;
            end
        end
        checks++;
        if (fa != 0 || fv - fa != FILL_LAT) begin
            failures++;
            $display("FAIL fill_latency: first_accept=%0d first_valid=%0d, required 0 and %0d", fa, fv, FILL_LAT);
        end
        checks++;
        if (nv != nc) begin
            failures++;
            $display("FAIL throughput: valid cycles=%0d of %0d, required all", nv, nc);
        end
    endtask

    task automatic test_stall();
        int n;
        n = 0;
        do_reset();
        set_mode(1, 1, 100, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_req_fire) n++;
        end
        checks++;
        if (n != M_DEPTH || obs_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_credits: accepted=%0d req_valid=%b, required %0d and 0", n, obs_req_valid, M_DEPTH);
        end
        n_consumed = 0;
        set_mode(1, 2, 100, 0, 100, 0);
        repeat (20) step();
        checks++;
        if (n_consumed < 12) begin
            failures++;
            $display("FAIL stall_release: consumed=%0d, required at least 12", n_consumed);
        end
    endtask

    task automatic test_redirect();
        bit seen, redir;
        int inflight;
        seen = 1'b0; redir = 1'b0; inflight = 0;
        do_reset();
        set_mode(3, 3, 100, 0, 100, 0);
        redir_map[32'h10] = 32'h0000_0103;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (obs_redirect && !redir) begin
                redir = 1'b1;
                inflight = last_redir_inflight;
            end
            if (redir && obs_inst_valid && obs_inst_pc == 32'h100) seen = 1'b1;
        end
        checks++;
        if (!seen || inflight < 2) begin
            failures++;
            $display("FAIL redirect_0x100: reached=%0d inflight_at_redirect=%0d, required 1 and >=2", seen, inflight);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        seen = 1'b0;
        do_reset();
        set_mode(4, 4, 100, 0, 100, 0);
        redir_map[32'h20]  = 32'h200;
        redir_map[32'h200] = 32'h300;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            if (obs_inst_valid && obs_inst_pc == 32'h300) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL back_to_back: 0x300 reached=%0d, required 1 within 80 cycles", seen);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hFFFF_FFF8; exp_w[1] = 32'hFFFF_FFFC; exp_w[2] = 32'h0000_0000;
        do_reset();
        set_mode(1, 1, 100, 0, 100, 0);
        repeat (8) step();
        checks++;
        if (w_addrs.size() < 3 || w_pcs.size() < 3) begin
            failures++;
            $display("FAIL wrap_count: requests=%0d insts=%0d, required >=3 each", w_addrs.size(), w_pcs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (w_addrs[i] !== exp_w[i] || w_pcs[i] !== exp_w[i]) begin
                    failures++;
                    $display("FAIL wrap_seq[%0d]: req=%h pc=%h, required %h", i, w_addrs[i], w_pcs[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_mode(1, 1, 100, 0, 0, 0);
        repeat (8) step();
        checks++;
        if (m_inst_valid !== 1'b1 || m_if.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_before_reset: inst_valid=%b req_valid=%b, required 1 0",
                     m_inst_valid, m_if.imem_req_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_inst_valid !== 1'b0 || m_if.imem_req_valid !== 1'b0 || w_if.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: inst_valid=%b req_valid=%b wrap_req_valid=%b, required 0 0 0",
                     m_inst_valid, m_if.imem_req_valid, w_if.imem_req_valid);
        end
        do_reset();
        set_mode(1, 2, 100, 0, 100, 0);
        repeat (12) step();
        checks++;
        if (n_consumed == 0 || exp_pc < 32'h10) begin
            failures++;
            $display("FAIL restart: next expected pc=%h, required >= 00000010", exp_pc);
        end
    endtask

    task automatic test_random();
        do_reset();
        set_mode(1, 4, 70, 25, 70, 10);
        n_consumed = 0;
        repeat (3000) step();
        checks++;
        if (n_consumed < 100) begin
            failures++;
            $display("FAIL random_progress: consumed=%0d, required at least 100", n_consumed);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m_if.imem_req_ready = 1'b0; m_if.imem_rsp_valid = 1'b0; m_if.imem_rsp_data = '0;
        m_inst_ready = 1'b0; m_pcsel = 1'b0; m_alu = '0;
        w_if.imem_req_ready = 1'b1; w_if.imem_rsp_valid = 1'b0; w_if.imem_rsp_data = '0;
        w_inst_ready = 1'b1; w_pcsel = 1'b0; w_alu = '0;
        n_consumed = 0;
        set_mode(1, 1, 100, 0, 100, 0);
        test_reset();
        @(negedge clk);
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
